hlsm_result_checker: RTL and testbench

- Synthesizable scoreboard that sits directly downstream of an HLSM DUT and its HLSM_ref model in the HLSM test benches.
- Consumes the shared Start pulse, both Done strobes and both flattened output buses.
- Measures DUT Start-to-Done latency, compares DUT data against reference data, and detects timeouts and protocol violations.
- Exposes saturating transaction/error counters and sticky error flags for the bench to sample at end of run.

---
 rtl/hlsm_chk_pkg.sv | 16 +
 rtl/hlsm_result_checker_sat_counter.sv | 23 ++
 rtl/hlsm_result_checker.sv | 174 +++++++++++++++++
 tb/tb_hlsm_result_checker.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hlsm_chk_pkg.sv
// Shared constants for the HLSM result checker: FSM state codes and defaults.
// Latency: n/a (package only).
// Backpressure: n/a.
package hlsm_chk_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RUN      = 2'd1;
  localparam logic [1:0] WAIT_DUT = 2'd2;
  localparam logic [1:0] WAIT_REF = 2'd3;

  // Default counter width and transaction abort threshold
  localparam int DEF_CNTW    = 16;
  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/hlsm_result_checker_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Latency: q reflects inc one Clk edge later.
// Backpressure: none; inc is taken every edge it is high.
//
// Ports: Clk, Rst (sync, active-high), inc (count enable), q (count value).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hlsm_result_checker.sv
// Scoreboard for an HLSM DUT vs its reference: latency, data, timeout and
// protocol checks. Latency: flags/counters update one Clk edge after the
// deciding event. Backpressure: none; every input strobe is sampled each edge.
//
// Ports: Clk, Rst (sync, active-high); Start/Done/DoneRef strobes; Dout/DoutRef
// flattened output buses (word 0 in LSBs); Busy, TxnCount, ErrCount,
// LastLatency, sticky DataErr/LatErr/TimeoutErr/ProtoErr, one-cycle ErrPulse.
module hlsm_result_checker
  import hlsm_chk_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int NUM_OUT   = 2,
  parameter int LATENCY   = 6,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int CNTW      = DEF_CNTW
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         Start,
  input  logic                         Done,
  input  logic                         DoneRef,
  input  logic [NUM_OUT*DATAWIDTH-1:0] Dout,
  input  logic [NUM_OUT*DATAWIDTH-1:0] DoutRef,
  output logic                         Busy,
  output logic [CNTW-1:0]              TxnCount,
  output logic [CNTW-1:0]              ErrCount,
  output logic [CNTW-1:0]              LastLatency,
  output logic                         DataErr,
  output logic                         LatErr,
  output logic                         TimeoutErr,
  output logic                         ProtoErr,
  output logic                         ErrPulse
);

  localparam int BW   = NUM_OUT * DATAWIDTH;
  // cyc never exceeds TIMEOUT-1, so clog2(TIMEOUT) bits suffice; latency
  // (cyc+1) gets one extra bit so it can reach TIMEOUT itself.
  localparam int CYCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LW   = CYCW + 1;

  typedef logic [CYCW-1:0] cyc_t;
  typedef logic [LW-1:0]   lat_t;
  typedef logic [CNTW-1:0] cnt_t;

  logic [1:0]    state, state_nxt;
  cyc_t          cyc;
  lat_t          cap_lat;
  logic [BW-1:0] cap_dat;   // holds whichever side's data arrived first

  lat_t          lat_now;
  logic          in_txn;
  logic          complete, timeout, closing, start_ok;
  logic          cap_dut, cap_ref;
  logic [BW-1:0] cmp_a, cmp_b;
  lat_t          cmp_lat;
  logic          data_mis, lat_mis, txn_err, proto_evt, err_evt;

  assign lat_now = lat_t'(cyc) + lat_t'(1);
  assign in_txn  = (state != IDLE);
  assign Busy    = in_txn;

  // ---------------------------------------------------------------------------
  // Output/event decode: selects which data pair to compare this edge and
  // which side (if any) must be captured for a later comparison.
  // ---------------------------------------------------------------------------
  always_comb begin
    complete = 1'b0;
    cap_dut  = 1'b0;
    cap_ref  = 1'b0;
    cmp_a    = Dout;
    cmp_b    = DoutRef;
    cmp_lat  = lat_now;
    case (state)
      RUN: begin
        complete = Done && DoneRef;
        cap_dut  = Done && !DoneRef;
        cap_ref  = DoneRef && !Done;
      end
      WAIT_DUT: begin
        complete = Done;
        cmp_b    = cap_dat;
      end
      WAIT_REF: begin
        complete = DoneRef;
        cmp_a    = cap_dat;
        cmp_lat  = cap_lat;   // DUT finished earlier; use its recorded latency
      end
      default: ;
    endcase
  end

  // Per-word bitwise equality
  logic [NUM_OUT-1:0] word_ne;
  for (genvar w = 0; w < NUM_OUT; w++) begin : g_cmp
    assign word_ne[w] = (cmp_a[w*DATAWIDTH +: DATAWIDTH] != cmp_b[w*DATAWIDTH +: DATAWIDTH]);
  end
  assign data_mis = |word_ne;

  // A completion on the abort edge wins over the timeout.
  assign timeout   = in_txn && !complete && (lat_now == lat_t'(TIMEOUT));
  assign closing   = complete || timeout;
  // Start is legal when idle or on the very edge the open transaction closes.
  assign start_ok  = Start && (!in_txn || closing);
  assign lat_mis   = (cmp_lat != lat_t'(LATENCY));
  assign txn_err   = (complete && (data_mis || lat_mis)) || timeout;
  assign proto_evt = (!in_txn && (Done || DoneRef)) || (Start && in_txn && !closing);
  // txn_err and proto_evt are mutually exclusive, so one increment per edge covers both.
  assign err_evt   = txn_err || proto_evt;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (Start) state_nxt = RUN;
      RUN: begin
        if (cap_dut)      state_nxt = WAIT_REF;
        else if (cap_ref) state_nxt = WAIT_DUT;
      end
      default: ;
    endcase
    if (closing) state_nxt = start_ok ? RUN : IDLE;
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      cyc         <= '0;
      cap_dat     <= '0;
      cap_lat     <= '0;
      LastLatency <= '0;
      DataErr     <= 1'b0;
      LatErr      <= 1'b0;
      TimeoutErr  <= 1'b0;
      ProtoErr    <= 1'b0;
      ErrPulse    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok)    cyc <= '0;
      else if (in_txn) cyc <= cyc + cyc_t'(1);
      if (cap_dut) begin
        cap_dat <= Dout;
        cap_lat <= lat_now;
      end else if (cap_ref) begin
        cap_dat <= DoutRef;
      end
      if (complete)             LastLatency <= cnt_t'(cmp_lat);
      if (complete && data_mis) DataErr     <= 1'b1;
      if (complete && lat_mis)  LatErr      <= 1'b1;
      if (timeout)              TimeoutErr  <= 1'b1;
      if (proto_evt)            ProtoErr    <= 1'b1;
      ErrPulse <= err_evt;
    end
  end

  sat_counter #(.W(CNTW)) u_txn_cnt (
    .Clk (Clk),
    .Rst (Rst),
    .inc (closing),
    .q   (TxnCount)
  );

  sat_counter #(.W(CNTW)) u_err_cnt (
    .Clk (Clk),
    .Rst (Rst),
    .inc (err_evt),
    .q   (ErrCount)
  );

endmodule

// File: tb/tb_hlsm_result_checker.sv
// Self-checking bench for hlsm_result_checker: directed scenarios plus random
// transactions checked against a transaction-level model of the expected results.
module tb_hlsm_result_checker;

  localparam int TMO = 64;
  localparam int LAT = 6;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Start = 1'b0, Done = 1'b0, DoneRef = 1'b0;
  logic [63:0] Dout = '0, DoutRef = '0;

  logic        Busy, DataErr, LatErr, TimeoutErr, ProtoErr, ErrPulse;
  logic [15:0] TxnCount, ErrCount, LastLatency;
  logic        s_busy, s_derr, s_lerr, s_terr, s_perr, s_pulse;
  logic [3:0]  s_txn, s_err, s_lat;

  always #5 Clk = ~Clk;

  hlsm_result_checker dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Done(Done), .DoneRef(DoneRef),
    .Dout(Dout), .DoutRef(DoutRef), .Busy(Busy), .TxnCount(TxnCount),
    .ErrCount(ErrCount), .LastLatency(LastLatency), .DataErr(DataErr),
    .LatErr(LatErr), .TimeoutErr(TimeoutErr), .ProtoErr(ProtoErr), .ErrPulse(ErrPulse)
  );

  // Narrow-counter copy on the same stimulus, used to observe saturation.
  hlsm_result_checker #(.CNTW(4)) dut_small (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Done(Done), .DoneRef(DoneRef),
    .Dout(Dout), .DoutRef(DoutRef), .Busy(s_busy), .TxnCount(s_txn),
    .ErrCount(s_err), .LastLatency(s_lat), .DataErr(s_derr),
    .LatErr(s_lerr), .TimeoutErr(s_terr), .ProtoErr(s_perr), .ErrPulse(s_pulse)
  );

  int n_vec = 0, n_bad = 0;

  // Transaction-level model state
  int m_txn, m_err, m_lat, m_pulse;
  bit m_derr, m_lerr, m_terr, m_perr;

  int obs_pulses = 0, pulse_base = 0;
  always @(negedge Clk) if (ErrPulse === 1'b1) obs_pulses++;

  logic [69:0] obs_vec;
  assign obs_vec = {Busy, TxnCount, ErrCount, LastLatency, DataErr, LatErr, TimeoutErr, ProtoErr,
                    s_busy, s_txn, s_err, s_lat, s_derr, s_lerr, s_terr, s_perr};

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic logic [69:0] exp_vec(input bit busy);
    logic [15:0] t16, e16, l16;
    logic [3:0]  t4, e4, l4;
    t16 = 16'(sat(m_txn, 65535));
    e16 = 16'(sat(m_err, 65535));
    l16 = 16'(m_lat);
    t4  = 4'(sat(m_txn, 15));
    e4  = 4'(sat(m_err, 15));
    l4  = 4'(m_lat);
    return {busy, t16, e16, l16, m_derr, m_lerr, m_terr, m_perr,
            busy, t4, e4, l4, m_derr, m_lerr, m_terr, m_perr};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Start = 0; Done = 0; DoneRef = 0; Dout = '0; DoutRef = '0;
    Rst = 1;
    tick();
    Rst = 0;
    m_txn = 0; m_err = 0; m_lat = 0; m_pulse = 0;
    m_derr = 0; m_lerr = 0; m_terr = 0; m_perr = 0;
    pulse_base = obs_pulses;
  endtask

  // One transaction: Done after dd edges, DoneRef after dr edges (beyond TMO
  // means never). extra>0 adds a stray Start at that offset; skip_start means
  // the Start was already taken on the previous completion edge; chain issues
  // the next Start on this transaction's closing edge.
  task automatic run_txn(input string nm, input int dd, input int dr,
                         input logic [63:0] vd, input logic [63:0] vr,
                         input int extra, input bit skip_start, input bit chain);
    bit tmo;
    int last;
    tmo  = (dd > TMO) || (dr > TMO);
    last = tmo ? TMO : ((dd > dr) ? dd : dr);
    if (!skip_start) begin
      Start = 1;
      tick();
      Start = 0;
    end
    n_vec++;
    if (Busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s busy: got %b want 1", nm, Busy);
    end
    for (int j = 1; j <= last; j++) begin
      Start   = (j == extra) || (chain && (j == last));
      Done    = (j == dd);
      DoneRef = (j == dr);
      Dout    = (j == dd) ? vd : {$urandom, $urandom};
      DoutRef = (j == dr) ? vr : {$urandom, $urandom};
      tick();
    end
    Start = 0; Done = 0; DoneRef = 0;
    if (extra > 0) begin
      m_err++; m_perr = 1; m_pulse++;
    end
    m_txn++;
    if (tmo) begin
      m_terr = 1; m_err++; m_pulse++;
    end else begin
      m_lat = dd;
      if (vd != vr) m_derr = 1;
      if (dd != LAT) m_lerr = 1;
      if ((vd != vr) || (dd != LAT)) begin
        m_err++; m_pulse++;
      end
    end
    n_vec++;
    if (obs_vec !== exp_vec(chain)) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, obs_vec, exp_vec(chain));
    end
  endtask

  task automatic check_pulses(input string nm);
    tick();
    n_vec++;
    if ((obs_pulses - pulse_base) != m_pulse) begin
      n_bad++;
      $display("FAIL %s pulses: got %0d want %0d", nm, obs_pulses - pulse_base, m_pulse);
    end
  endtask

  task automatic test_reset();
    Rst = 1;
    tick(); tick();
    do_reset();
    repeat (3) tick();
    n_vec++;
    if (obs_vec !== exp_vec(1'b0)) begin
      n_bad++;
      $display("FAIL reset: got %h want %h", obs_vec, exp_vec(1'b0));
    end
  endtask

  task automatic test_basic();
    do_reset();
    repeat (8) tick();
    run_txn("basic", 6, 6, {32'h5, 32'h7}, {32'h5, 32'h7}, 0, 0, 0);
    check_pulses("basic");
  endtask

  task automatic test_wait_dut();
    do_reset();
    run_txn("wait_dut", 8, 6, {32'h1234, 32'h9}, {32'h1234, 32'h9}, 0, 0, 0);
    check_pulses("wait_dut");
  endtask

  task automatic test_wait_ref();
    do_reset();
    run_txn("wait_ref", 4, 6, {32'hDEAD, 32'h7}, {32'hBEEF, 32'h7}, 0, 0, 0);
    check_pulses("wait_ref");
  endtask

  task automatic test_timeout();
    do_reset();
    run_txn("timeout", 100, 100, 64'h0, 64'h0, 0, 0, 0);
    check_pulses("timeout");
    // Completion on the abort edge itself still counts as a completion.
    run_txn("done_at_tmo", TMO, TMO, 64'h11, 64'h11, 0, 0, 0);
    check_pulses("done_at_tmo");
  endtask

  task automatic test_proto();
    do_reset();
    run_txn("proto_start", 6, 6, {32'h5, 32'h7}, {32'h5, 32'h7}, 3, 0, 0);
    tick();
    Done = 1;
    tick();
    Done = 0;
    m_err++; m_perr = 1; m_pulse++;
    tick();
    n_vec++;
    if (obs_vec !== exp_vec(1'b0)) begin
      n_bad++;
      $display("FAIL proto_idle: got %h want %h", obs_vec, exp_vec(1'b0));
    end
    check_pulses("proto");
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_txn("b2b_a", 6, 5, 64'hA, 64'hA, 0, 0, 1);
    run_txn("b2b_b", 6, 7, 64'hB, 64'hC, 0, 1, 0);
    check_pulses("b2b");
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_txn("pre_rst", 7, 7, 64'h1, 64'h2, 0, 0, 0);
    Start = 1;
    tick();
    Start = 0;
    tick(); tick();
    do_reset();
    n_vec++;
    if (obs_vec !== exp_vec(1'b0)) begin
      n_bad++;
      $display("FAIL reset_mid: got %h want %h", obs_vec, exp_vec(1'b0));
    end
    run_txn("post_rst", 6, 6, 64'h77, 64'h77, 0, 0, 0);
    check_pulses("reset_mid");
  endtask

  task automatic test_saturation();
    do_reset();
    for (int t = 0; t < 18; t++) begin
      run_txn("sat", 7, 7, 64'(t), 64'(t), 0, 0, 0);
    end
    check_pulses("sat");
  endtask

  function automatic int rdelay();
    if ($urandom % 8 == 0) return int'($urandom_range(60, 68));
    return int'($urandom_range(1, 10));
  endfunction

  task automatic test_random();
    bit pend = 0;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      int dd, dr, last, extra, ngap;
      bit tmo, chain;
      logic [63:0] vr, vd;
      dd    = rdelay();
      dr    = rdelay();
      tmo   = (dd > TMO) || (dr > TMO);
      last  = tmo ? TMO : ((dd > dr) ? dd : dr);
      chain = !tmo && ($urandom % 4 == 0) && (t < 39);
      extra = ((last > 2) && ($urandom % 6 == 0)) ? int'($urandom_range(1, last - 1)) : 0;
      vr    = {$urandom, $urandom};
      vd    = ($urandom % 2 == 0) ? vr : (vr ^ (64'(1) << ($urandom % 64)));
      run_txn("random", dd, dr, vd, vr, extra, pend, chain);
      pend = chain;
      if (!chain) begin
        ngap = int'($urandom % 3);
        for (int g = 0; g < ngap; g++) begin
          Done = ($urandom % 8 == 0);
          if (Done) begin
            m_err++; m_perr = 1; m_pulse++;
          end
          tick();
          Done = 0;
        end
      end
    end
    check_pulses("random");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_dut();
    test_wait_ref();
    test_timeout();
    test_proto();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
